// File: rtl/execute_stage_if.sv
// ---------------------------------------------------------------------------
// execute_stage_if
//   Bundles the decode->execute operand bus, the execute->memory result bus,
//   the fetch redirect and the hazard/hold signals of the execute stage.
//
//   master : decode side (drives EXE_*, operands, MEM_STALL; observes results)
//   slave  : execute_stage itself
//
//   Handshake: decode presents EXE_V with its operands and keeps them steady
//   until an edge where EXE_BUSY is low; that edge consumes the slot.  The
//   memory stage signals it cannot accept with MEM_STALL, which freezes every
//   registered output and forces EXE_BUSY high for the same cycle.
//
//   DBG_STATE / DBG_CNT expose the multiply sequencer for checkers.
// ---------------------------------------------------------------------------
interface execute_stage_if;
    logic        EXE_V;
    logic [31:0] EXE_IR;
    logic [63:0] EXE_NPC;
    logic [63:0] ALU1;
    logic [63:0] ALU2;
    logic [63:0] TARGET_ADDRESS;
    logic [63:0] MEM_ADDRESS;
    logic        MEM_STALL;

    logic        MEM_V;
    logic [31:0] MEM_IR;
    logic [63:0] MEM_RESULT;
    logic [63:0] MEM_ADDR;
    logic [63:0] MEM_STORE_DATA;
    logic        BR_TAKEN;
    logic [63:0] BR_TARGET;
    logic [4:0]  EXE_RD;
    logic        EXE_BUSY;

    logic        DBG_STATE;
    logic [1:0]  DBG_CNT;

    modport master (
        output EXE_V, EXE_IR, EXE_NPC, ALU1, ALU2, TARGET_ADDRESS, MEM_ADDRESS,
               MEM_STALL,
        input  MEM_V, MEM_IR, MEM_RESULT, MEM_ADDR, MEM_STORE_DATA, BR_TAKEN,
               BR_TARGET, EXE_RD, EXE_BUSY, DBG_STATE, DBG_CNT
    );

    modport slave (
        input  EXE_V, EXE_IR, EXE_NPC, ALU1, ALU2, TARGET_ADDRESS, MEM_ADDRESS,
               MEM_STALL,
        output MEM_V, MEM_IR, MEM_RESULT, MEM_ADDR, MEM_STORE_DATA, BR_TAKEN,
               BR_TARGET, EXE_RD, EXE_BUSY, DBG_STATE, DBG_CNT
    );
endinterface

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   RV64 integer execute stage: ALU ops, load/store address pass-through,
//   LUI/AUIPC, branches and JAL, plus a 4-cycle multiply sequenced by a small
//   IDLE/MUL_WAIT state machine.
//
//   Ports:
//     CLK    - sole clock, rising edge
//     RESET  - synchronous, active-high; aborts an in-flight multiply
//     bus    - execute_stage_if.slave (operands in, MEM_*/BR_* registered out,
//              EXE_RD hazard destination, EXE_BUSY hold, debug state)
//
//   A "capture edge" is any edge with EXE_BUSY low.  On it the MEM_* registers
//   are reloaded: with the result of an accepted instruction, or with an
//   all-zero bubble (no valid input, unsupported opcode, or wrong-path slot
//   behind a taken branch).  Non-taken branches and bubbles leave BR_TARGET 0.
// ---------------------------------------------------------------------------
module execute_stage (
    input  logic           CLK,
    input  logic           RESET,
    execute_stage_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, MUL_WAIT = 1'b1} state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [1:0] CNT_LAST  = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] mul_a_q, mul_a_d;
    logic [63:0] mul_b_q, mul_b_d;
    logic [31:0] mul_ir_q, mul_ir_d;
    logic        mem_v_q, mem_v_d;
    logic [31:0] mem_ir_q, mem_ir_d;
    logic [63:0] mem_result_q, mem_result_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_store_q, mem_store_d;
    logic        br_taken_q, br_taken_d;
    logic [63:0] br_target_q, br_target_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [5:0]  shamt;
    logic [63:0] a, b;
    logic        op_ok, op_mul, op_br;
    logic [63:0] op_result, op_addr, op_store;
    logic        busy, capture, accept, mul_done;
    logic [63:0] mul_product;
    logic        rd_writer;
    logic        unused_ir_bits;

    assign opcode = bus.EXE_IR[6:0];
    assign funct3 = bus.EXE_IR[14:12];
    assign funct7 = bus.EXE_IR[31:25];
    assign a      = bus.ALU1;
    assign b      = bus.ALU2;
    assign shamt  = bus.ALU2[5:0];

    // Register-specifier fields are resolved by decode; execute only forwards IR.
    assign unused_ir_bits = ^{bus.EXE_IR[24:15], bus.EXE_IR[11:7]};

    assign busy     = bus.MEM_STALL | (state_q != IDLE);
    assign capture  = ~busy;
    // The slot right behind a taken branch is wrong-path and gets squashed.
    assign accept   = capture & bus.EXE_V & ~br_taken_q & op_ok;
    assign mul_done = (state_q == MUL_WAIT) & (cnt_q == CNT_LAST) & ~bus.MEM_STALL;
    assign mul_product = mul_a_q * mul_b_q;

    // ---------------- instruction decode / ALU ----------------
    always_comb begin
        op_ok     = 1'b0;
        op_mul    = 1'b0;
        op_br     = 1'b0;
        op_result = 64'd0;
        op_addr   = 64'd0;
        op_store  = 64'd0;
        case (opcode)
            OP_LOAD: begin
                op_ok   = 1'b1;
                op_addr = bus.MEM_ADDRESS;
            end
            OP_STORE: begin
                op_ok    = 1'b1;
                op_addr  = bus.MEM_ADDRESS;
                op_store = b;
            end
            OP_RTYPE: begin
                case (funct7)
                    7'b0000000: begin
                        op_ok = 1'b1;
                        case (funct3)
                            3'b000:  op_result = a + b;
                            3'b001:  op_result = a << shamt;
                            3'b010:  op_result = {63'd0, $signed(a) < $signed(b)};
                            3'b011:  op_result = {63'd0, a < b};
                            3'b100:  op_result = a ^ b;
                            3'b101:  op_result = a >> shamt;
                            3'b110:  op_result = a | b;
                            default: op_result = a & b;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            op_ok     = 1'b1;
                            op_result = a - b;
                        end else if (funct3 == 3'b101) begin
                            op_ok     = 1'b1;
                            op_result = $signed(a) >>> shamt;
                        end
                    end
                    7'b0000001: begin
                        if (funct3 == 3'b000) begin
                            op_ok  = 1'b1;
                            op_mul = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OP_LUI: begin
                op_ok     = 1'b1;
                op_result = a;
            end
            OP_AUIPC: begin
                op_ok     = 1'b1;
                op_result = (bus.EXE_NPC - 64'd4) + a;
            end
            OP_BRANCH: begin
                op_ok = 1'b1;
                case (funct3)
                    3'b000:  op_br = (a == b);
                    3'b001:  op_br = (a != b);
                    3'b100:  op_br = ($signed(a) <  $signed(b));
                    3'b101:  op_br = ($signed(a) >= $signed(b));
                    3'b110:  op_br = (a <  b);
                    3'b111:  op_br = (a >= b);
                    default: op_ok = 1'b0;
                endcase
            end
            OP_JAL: begin
                op_ok     = 1'b1;
                op_br     = 1'b1;
                op_result = bus.EXE_NPC;
            end
            default: ;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            mul_a_q      <= 64'd0;
            mul_b_q      <= 64'd0;
            mul_ir_q     <= 32'd0;
            mem_v_q      <= 1'b0;
            mem_ir_q     <= 32'd0;
            mem_result_q <= 64'd0;
            mem_addr_q   <= 64'd0;
            mem_store_q  <= 64'd0;
            br_taken_q   <= 1'b0;
            br_target_q  <= 64'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_ir_q     <= mul_ir_d;
            mem_v_q      <= mem_v_d;
            mem_ir_q     <= mem_ir_d;
            mem_result_q <= mem_result_d;
            mem_addr_q   <= mem_addr_d;
            mem_store_q  <= mem_store_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
        end
    end

    // ---------------- next state ----------------
    // CNT keeps counting while the memory stage stalls, then parks at 2 until
    // the result can be written.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && op_mul) begin
                    state_d = MUL_WAIT;
                    cnt_d   = 2'd0;
                end
            end
            MUL_WAIT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 2'd1;
                end else if (!bus.MEM_STALL) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            end
        endcase
    end

    // ---------------- outputs / datapath ----------------
    always_comb begin
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_ir_d     = mul_ir_q;
        mem_v_d      = mem_v_q;
        mem_ir_d     = mem_ir_q;
        mem_result_d = mem_result_q;
        mem_addr_d   = mem_addr_q;
        mem_store_d  = mem_store_q;
        br_taken_d   = br_taken_q;
        br_target_d  = br_target_q;
        if (capture) begin
            // Bubble unless the slot is accepted; a multiply also leaves a
            // bubble behind while it runs.
            mem_v_d      = 1'b0;
            mem_ir_d     = 32'd0;
            mem_result_d = 64'd0;
            mem_addr_d   = 64'd0;
            mem_store_d  = 64'd0;
            br_taken_d   = 1'b0;
            br_target_d  = 64'd0;
            if (accept) begin
                if (op_mul) begin
                    mul_a_d  = a;
                    mul_b_d  = b;
                    mul_ir_d = bus.EXE_IR;
                end else begin
                    mem_v_d      = 1'b1;
                    mem_ir_d     = bus.EXE_IR;
                    mem_result_d = op_result;
                    mem_addr_d   = op_addr;
                    mem_store_d  = op_store;
                    br_taken_d   = op_br;
                    br_target_d  = op_br ? bus.TARGET_ADDRESS : 64'd0;
                end
            end
        end else if (mul_done) begin
            mem_v_d      = 1'b1;
            mem_ir_d     = mul_ir_q;
            mem_result_d = mul_product;
            mem_addr_d   = 64'd0;
            mem_store_d  = 64'd0;
            br_taken_d   = 1'b0;
            br_target_d  = 64'd0;
        end
    end

    always_comb begin
        rd_writer = 1'b0;
        case (mem_ir_q[6:0])
            OP_LOAD, OP_RTYPE, OP_LUI, OP_AUIPC, OP_JAL: rd_writer = 1'b1;
            default: ;
        endcase
    end

    assign bus.EXE_BUSY       = busy;
    assign bus.EXE_RD         = (mem_v_q && rd_writer) ? mem_ir_q[11:7] : 5'd0;
    assign bus.MEM_V          = mem_v_q;
    assign bus.MEM_IR         = mem_ir_q;
    assign bus.MEM_RESULT     = mem_result_q;
    assign bus.MEM_ADDR       = mem_addr_q;
    assign bus.MEM_STORE_DATA = mem_store_q;
    assign bus.BR_TAKEN       = br_taken_q;
    assign bus.BR_TARGET      = br_target_q;
    assign bus.DBG_STATE      = state_q;
    assign bus.DBG_CNT        = cnt_q;
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-003 SHALL have inputs EXE_V  in  1, EXE_IR  in  32, EXE_NPC  in  64; these carry the valid bit, the instruction, and PC+4 from decode.
REQ-004 SHALL have inputs ALU1, ALU2, TARGET_ADDRESS, MEM_ADDRESS  in  64 each; these are the operands from decode.
REQ-005 SHALL have input MEM_STALL  in  1, meaning the downstream memory stage cannot accept.
REQ-006 SHALL have outputs MEM_V  out  1 and MEM_IR  out  32, the registered valid bit and instruction to the memory stage.
REQ-007 SHALL have outputs MEM_RESULT, MEM_ADDR, MEM_STORE_DATA  out  64 each, all registered.
REQ-008 SHALL have outputs BR_TAKEN  out  1 and BR_TARGET  out  64, the registered redirect to fetch.
REQ-009 SHALL have outputs EXE_RD  out  5 (hazard destination to decode) and EXE_BUSY  out  1 (decode must hold).

Function
REQ-010 SHALL capture inputs into MEM_* registers at the rising edge when EXE_V=1, EXE_BUSY=0 and BR_TAKEN=0; latency is 1 cycle, or 4 cycles for MUL.
REQ-011 SHALL load MEM_V=0 on a capture edge when EXE_V=0, the opcode is unsupported, or BR_TAKEN=1 (wrong-path squash); MEM_IR=0 in that case.
REQ-012 SHALL, when MEM_STALL=1, hold every MEM_*, BR_* and EXE_RD value and assert EXE_BUSY.
REQ-013 SHALL drive EXE_BUSY = MEM_STALL | (state != IDLE) as a combinational signal.
REQ-014 Load (0000011): MEM_ADDR=MEM_ADDRESS; MEM_RESULT=0.
REQ-015 Store (0100011): MEM_ADDR=MEM_ADDRESS; MEM_STORE_DATA=ALU2.
REQ-016 R-type (0110011), funct7 0000000/0100000: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND on ALU1/ALU2.
REQ-017 Shift amounts SHALL use ALU2[5:0]; SLT is signed, SLTU unsigned; results are 64-bit and wrap modulo 2^64.
REQ-018 R-type funct7=0000001 with funct3=000 is MUL: MEM_RESULT = low 64 bits of ALU1*ALU2.
REQ-019 Other funct7/funct3 combinations SHALL be squashed as unsupported.
REQ-020 LUI (0110111): MEM_RESULT=ALU1.
REQ-021 AUIPC (0010111): MEM_RESULT=(EXE_NPC-4)+ALU1.
REQ-022 Branch (1100011): BEQ/BNE/BLT/BGE/BLTU/BGEU compare ALU1 vs ALU2; if taken, BR_TAKEN=1 and BR_TARGET=TARGET_ADDRESS; MEM_V=1, MEM_RESULT=0.
REQ-023 JAL (1101111): BR_TAKEN=1, BR_TARGET=TARGET_ADDRESS, MEM_RESULT=EXE_NPC.
REQ-024 BR_TAKEN SHALL be a one-cycle pulse aligned with MEM_V; it SHALL be cleared on the next non-stalled edge and held while MEM_STALL=1.
REQ-025 EXE_RD SHALL equal MEM_IR[11:7] when MEM_V=1 and the opcode writes rd (load, R-type, LUI, AUIPC, JAL), else 0.
REQ-026 State machine SHALL have states IDLE and MUL_WAIT and a 2-bit counter CNT.
REQ-027 IDLE->MUL_WAIT on an accepted MUL: latch operands, set CNT=0; MEM_V stays 0 and EXE_BUSY is 1.
REQ-028 MUL_WAIT SHALL increment CNT each cycle; when CNT=2 and MEM_STALL=0, it writes the MUL result to MEM_* with MEM_V=1 and returns to IDLE.
REQ-029 MUL_WAIT SHALL hold at CNT=2 while MEM_STALL=1.
REQ-030 Inputs SHALL be ignored while EXE_BUSY=1; decode holds them.
REQ-031 Simultaneous MEM_STALL=1 and a valid EXE_V: the stall wins and the instruction is not consumed.

Reset
REQ-032 On RESET=1 at a clock edge: MEM_V=0, MEM_IR=0, MEM_RESULT=MEM_ADDR=MEM_STORE_DATA=0, BR_TAKEN=0, BR_TARGET=0, state=IDLE, CNT=0.
REQ-033 RESET SHALL abort an in-flight MUL without producing a result; EXE_RD=0 and EXE_BUSY=MEM_STALL the cycle after reset.
REQ-034 RESET SHALL take priority over every other event.

Verification
REQ-035 ADD x3: ALU1=5, ALU2=0xFFFFFFFFFFFFFFFF, EXE_V=1 -> next cycle MEM_V=1, MEM_RESULT=4, EXE_RD=3.
REQ-036 MUL x7: ALU1=0x1_0000_0000, ALU2=0x1_0000_0001 -> EXE_BUSY=1 for 3 cycles; at edge 4 MEM_V=1, MEM_RESULT=0x0000000100000000, EXE_RD=7.
REQ-037 BLTU with ALU1=1, ALU2=2, TARGET_ADDRESS=0x1000, then a valid ADD presented the following cycle -> BR_TAKEN=1 and BR_TARGET=0x1000 for one cycle; the ADD is squashed (MEM_V=0, MEM_IR=0).
REQ-038 SW: MEM_ADDRESS=0x2008, ALU2=0xAB, with MEM_STALL=1 for 2 cycles mid-flow -> outputs frozen, EXE_BUSY=1; after release MEM_ADDR=0x2008, MEM_STORE_DATA=0xAB.
REQ-039 RESET=1 during MUL_WAIT CNT=1 -> next cycle state IDLE, MEM_V=0, EXE_BUSY=0, no result appears.
REQ-040 Unknown opcode 0x7F with EXE_V=1 -> MEM_V=0, MEM_IR=0, EXE_RD=0.
